// File: rtl/pool_stage_param.sv
// 2x2/stride-2 signed max/average pooling stage between two feature-map BRAMs.
// Optional macro POOL_RELU_EN fuses a ReLU (negative results clamp to 0) ahead of the write register.
module pool_stage_param #(
  parameter int unsigned DW       = 16,
  parameter int unsigned IN_W     = 64,
  parameter int unsigned IN_H     = 32,
  parameter int unsigned SRC_AW   = 7,
  parameter int unsigned DST_AW   = 6,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pool_en,
  input  logic                     pool_mode,
  input  logic [IN_W*DW-1:0]       src_douta,
  input  logic [IN_W*DW-1:0]       src_doutb,
  output logic                     src_ena,
  output logic                     src_enb,
  output logic [SRC_AW-1:0]        src_addra,
  output logic [SRC_AW-1:0]        src_addrb,
  output logic                     dst_wea,
  output logic [DST_AW-1:0]        dst_addra,
  output logic [(IN_W/2)*DW-1:0]   dst_dina,
  output logic                     pool_busy,
  output logic                     pool_finish
);

  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned OUT_H = IN_H / 2;
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_next;
  logic [ROW_W-1:0]   row, row_next, rd_row;
  logic               drain_cnt, drain_next;
  logic               mode_q;
  logic               rd_valid;
  logic [OUT_W*DW-1:0] pooled;

  // Next-state: one RUN cycle per output row, two drain cycles for BRAM + pool register.
  always_comb begin
    state_next = state;
    row_next   = row;
    drain_next = drain_cnt;
    case (state)
      S_IDLE: begin
        row_next = '0;
        if (pool_en) state_next = S_RUN;
      end
      S_RUN: begin
        if (row == ROW_W'(OUT_H - 1)) begin
          state_next = S_DRAIN;
          drain_next = 1'b0;
        end else begin
          row_next = row + ROW_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt) state_next = S_DONE;
        else           drain_next = 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      row       <= row_next;
      drain_cnt <= drain_next;
    end
  end

  // Per-lane pooling of the 2x2 window {a,b / c,d}.
  for (genvar j = 0; j < OUT_W; j++) begin : g_lane
    logic signed [DW-1:0] a, b, c, d, mx_ab, mx_cd, mx, av, res;
    logic signed [DW+1:0] sum;
    assign a     = src_douta[(2*j)*DW +: DW];
    assign b     = src_douta[(2*j+1)*DW +: DW];
    assign c     = src_doutb[(2*j)*DW +: DW];
    assign d     = src_doutb[(2*j+1)*DW +: DW];
    assign mx_ab = (a > b) ? a : b;
    assign mx_cd = (c > d) ? c : d;
    assign mx    = (mx_ab > mx_cd) ? mx_ab : mx_cd;
    assign sum   = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (DW+2)'(d);
    assign av    = DW'(sum >>> 2);
    assign res   = mode_q ? av : mx;
`ifdef POOL_RELU_EN
    assign pooled[j*DW +: DW] = res[DW-1] ? '0 : res;
`else
    assign pooled[j*DW +: DW] = res;
`endif
  end

  // Registered read issue, pipeline tracking and write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ena     <= 1'b0;
      src_enb     <= 1'b0;
      src_addra   <= '0;
      src_addrb   <= '0;
      rd_valid    <= 1'b0;
      rd_row      <= '0;
      dst_wea     <= 1'b0;
      dst_addra   <= '0;
      dst_dina    <= '0;
      mode_q      <= 1'b0;
      pool_busy   <= 1'b0;
      pool_finish <= 1'b0;
    end else begin
      src_ena  <= (state_next == S_RUN);
      src_enb  <= (state_next == S_RUN);
      if (state_next == S_RUN) begin
        src_addra <= SRC_AW'(SRC_BASE) + SRC_AW'({row_next, 1'b0});
        src_addrb <= SRC_AW'(SRC_BASE) + SRC_AW'({row_next, 1'b1});
      end
      rd_valid <= src_ena;
      rd_row   <= row;
      dst_wea  <= rd_valid;
      if (rd_valid) begin
        dst_addra <= DST_AW'(DST_BASE) + DST_AW'(rd_row);
        dst_dina  <= pooled;
      end
      if (state == S_IDLE && pool_en) mode_q <= pool_mode;
      pool_busy   <= (state_next != S_IDLE);
      pool_finish <= (state_next == S_DONE);
    end
  end

endmodule
